// File: rtl/msk_and_rnd_sched.sv
// Issue scheduler for a bank of masked HPC2 AND gadgets.
// Buffers RNG words into two batch slots and drives the skewed gadget inputs.
module msk_and_rnd_sched #(
    parameter int D  = 2,
    parameter int N  = 5,
    parameter int RW = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RW-1:0]              rnd_in,
    input  logic                       rnd_in_valid,
    output logic                       rnd_in_ready,
    input  logic [N*D-1:0]             op_a,
    input  logic [N*D-1:0]             op_b,
    input  logic                       op_valid,
    output logic                       op_ready,
    output logic [N*D-1:0]             g_inb,
    output logic [N*D-1:0]             g_ina,
    output logic [N*D*(D-1)/2-1:0]     g_rnd,
    input  logic [N*D-1:0]             g_out,
    output logic [N*D-1:0]             res,
    output logic                       res_valid,
    output logic                       busy
);

    localparam int NRND = N * D * (D - 1) / 2;
    localparam int WPB  = NRND / RW;
    localparam int FCW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int ND   = N * D;

    logic [NRND-1:0] slot [2];
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic            wp;
    logic            rp;
    logic [FCW-1:0]  fc;
    logic            rnd_acc;
    logic            op_acc;
    logic            fc_last;
    logic            v1;
    logic            v2;
    logic            v3;
    logic [ND-1:0]   b_q;
    logic [ND-1:0]   a1_q;
    logic [ND-1:0]   a2_q;
    logic [NRND-1:0] r_q;

    assign rnd_in_ready = !full[wp];
    assign op_ready     = full[rp];
    assign rnd_acc      = rnd_in_valid && rnd_in_ready;
    assign op_acc       = op_valid && op_ready;
    assign fc_last      = (fc == FCW'(WPB - 1));

    // Consume and complete always hit different slots, so both updates apply.
    always_comb begin
        full_nxt = full;
        if (op_acc) begin
            full_nxt[rp] = 1'b0;
        end
        if (rnd_acc && fc_last) begin
            full_nxt[wp] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            fc   <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (rnd_acc) begin
                if (fc_last) begin
                    wp <= ~wp;
                    fc <= '0;
                end else begin
                    fc <= fc + 1'b1;
                end
            end
            if (op_acc) begin
                rp <= ~rp;
            end
            v1 <= op_acc;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Data path needs no reset: every output is gated by a stage-valid bit.
    always_ff @(posedge clk) begin
        if (rnd_acc) begin
            slot[wp][fc*RW +: RW] <= rnd_in;
        end
        if (op_acc) begin
            b_q  <= op_b;
            a1_q <= op_a;
            r_q  <= slot[rp];
        end
        if (v1) begin
            a2_q <= a1_q;
        end
    end

    assign g_inb     = v1 ? b_q  : '0;
    assign g_rnd     = v1 ? r_q  : '0;
    assign g_ina     = v2 ? a2_q : '0;
    assign res       = g_out;
    assign res_valid = v3;
    assign busy      = v1 || v2 || v3;

endmodule

// File: tb/tb_msk_and_rnd_sched.sv
// Bench for msk_and_rnd_sched with a behavioural HPC2 gadget bank (D=2).
// A cycle-stamped scoreboard predicts every driven gadget input and result.
module tb_msk_and_rnd_sched;

    localparam int D    = 2;
    localparam int N    = 5;
    localparam int RW   = 1;
    localparam int NRND = 5;
    localparam int WPB  = 5;
    localparam int ND   = 10;

    logic            clk;
    logic            rst;
    logic [RW-1:0]   rnd_in;
    logic            rnd_in_valid;
    logic            rnd_in_ready;
    logic [ND-1:0]   op_a;
    logic [ND-1:0]   op_b;
    logic            op_valid;
    logic            op_ready;
    logic [ND-1:0]   g_inb;
    logic [ND-1:0]   g_ina;
    logic [NRND-1:0] g_rnd;
    logic [ND-1:0]   g_out;
    logic [ND-1:0]   res;
    logic            res_valid;
    logic            busy;

    msk_and_rnd_sched #(.D(D), .N(N), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .rnd_in(rnd_in), .rnd_in_valid(rnd_in_valid), .rnd_in_ready(rnd_in_ready),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .g_inb(g_inb), .g_ina(g_ina), .g_rnd(g_rnd), .g_out(g_out),
        .res(res), .res_valid(res_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;
    bit ops_done = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] fold(input logic [ND-1:0] s);
        logic [N-1:0] p;
        for (int j = 0; j < N; j++) p[j] = s[2*j] ^ s[2*j+1];
        return p;
    endfunction

    // Behavioural HPC2 gadget bank: b/rnd registered first, a one cycle later.
    logic [ND-1:0] bb, bx, t_s, t_r, t_m;
    logic [N-1:0]  rr;
    always @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            rr[j] <= g_rnd[j];
            for (int i = 0; i < 2; i++) begin
                bb[2*j+i]  <= g_inb[2*j+i];
                bx[2*j+i]  <= g_inb[2*j+1-i] ^ g_rnd[j];
                t_s[2*j+i] <= g_ina[2*j+i] & bb[2*j+i];
                t_r[2*j+i] <= ~g_ina[2*j+i] & rr[j];
                t_m[2*j+i] <= g_ina[2*j+i] & bx[2*j+i];
            end
        end
    end
    assign g_out = t_s ^ t_r ^ t_m;

    typedef struct {
        int              t;
        logic [ND-1:0]   a;
        logic [ND-1:0]   b;
        logic [NRND-1:0] r;
        logic [N-1:0]    p;
    } ent_t;

    ent_t          sb[$];
    logic [RW-1:0] words[$];
    int            nbatch = 0;
    ent_t          rec_e;

    // Recorder: logs handshakes mid-cycle, ahead of the edge that takes them.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            words.delete();
            nbatch = 0;
        end else begin
            if (op_valid && op_ready) begin
                rec_e.t = cyc;
                rec_e.a = op_a;
                rec_e.b = op_b;
                rec_e.p = fold(op_a) & fold(op_b);
                rec_e.r = '0;
                chk("batch_available", 64'(words.size() >= (nbatch + 1) * WPB), 64'd1);
                if (words.size() >= (nbatch + 1) * WPB)
                    for (int k = 0; k < WPB; k++)
                        rec_e.r[k*RW +: RW] = words[nbatch*WPB + k];
                nbatch++;
                sb.push_back(rec_e);
            end
            if (rnd_in_valid && rnd_in_ready) words.push_back(rnd_in);
        end
    end

    logic [ND-1:0]   e_inb, e_ina;
    logic [NRND-1:0] e_rnd;
    logic [N-1:0]    e_p;
    logic            e_rv, e_busy;

    // Monitor: every cycle, compare all gadget drives and the result.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            e_inb = '0; e_ina = '0; e_rnd = '0; e_p = '0; e_rv = 0; e_busy = 0;
            foreach (sb[i]) begin
                if (sb[i].t == cyc - 1) begin e_inb = sb[i].b; e_rnd = sb[i].r; end
                if (sb[i].t == cyc - 2) e_ina = sb[i].a;
                if (sb[i].t == cyc - 3) begin e_rv = 1; e_p = sb[i].p; end
                if (sb[i].t >= cyc - 3 && sb[i].t <= cyc - 1) e_busy = 1;
            end
            chk("g_inb", 64'(g_inb), 64'(e_inb));
            chk("g_rnd", 64'(g_rnd), 64'(e_rnd));
            chk("g_ina", 64'(g_ina), 64'(e_ina));
            chk("res_valid", 64'(res_valid), 64'(e_rv));
            chk("busy", 64'(busy), 64'(e_busy));
            if (e_rv) chk("res_and", 64'(fold(res)), 64'(e_p));
            while (sb.size() > 0 && sb[0].t <= cyc - 3) void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_word(input logic [RW-1:0] w);
        bit got = 0;
        rnd_in = w;
        rnd_in_valid = 1;
        for (int n = 0; n < 50; n++) begin
            got = rnd_in_ready;
            tick();
            if (got) break;
        end
        chk("rnd_accept_timeout", 64'(got), 64'd1);
        rnd_in_valid = 0;
    endtask

    task automatic issue_op(input logic [ND-1:0] a, input logic [ND-1:0] b);
        bit got = 0;
        op_a = a;
        op_b = b;
        op_valid = 1;
        for (int n = 0; n < 200; n++) begin
            got = op_ready;
            tick();
            if (got) break;
        end
        chk("op_accept_timeout", 64'(got), 64'd1);
        op_valid = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [RW-1:0] fill1 [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [RW-1:0] fill2 [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1; rnd_in = '0; rnd_in_valid = 0;
        op_a = '0; op_b = '0; op_valid = 0;
        tick(); tick();
        chk("rst_rnd_in_ready", 64'(rnd_in_ready), 64'd1);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_g_all", 64'({g_inb, g_ina, g_rnd}), 64'd0);
        rst = 0;
        mon_en = 1;

        // Fill the first batch: 1,0,1,1,0 -> 5'b01101
        for (int i = 0; i < 5; i++) begin
            feed_word(fill1[i]);
            if (i == 3) chk("fill_op_ready_4w", 64'(op_ready), 64'd0);
        end
        chk("fill_op_ready_5w", 64'(op_ready), 64'd1);

        // Single op: x=5'b10100, y=5'b11011, x&y=5'b10000
        issue_op(10'h2D3, 10'h1B6);
        chk("single_g_inb", 64'(g_inb), 64'h1B6);
        chk("single_g_rnd", 64'(g_rnd), 64'b01101);
        tick();
        chk("single_g_ina", 64'(g_ina), 64'h2D3);
        tick();
        chk("single_res_valid", 64'(res_valid), 64'd1);
        chk("single_res_and", 64'(fold(res)), 64'h10);
        tick();
        chk("single_res_done", 64'(res_valid), 64'd0);

        // Stall without randomness
        op_a = 10'h0F0; op_b = 10'h33C; op_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_op_ready", 64'(op_ready), 64'd0);
        end
        op_valid = 0;

        // Two batches 5'b10110, 5'b10011 then full backpressure
        for (int i = 0; i < 10; i++) feed_word(fill2[i]);
        rnd_in = 1'b1; rnd_in_valid = 1;
        tick();
        chk("bp_rnd_in_ready", 64'(rnd_in_ready), 64'd0);
        rnd_in_valid = 1;
        issue_op(10'h0F0, 10'h33C);
        chk("bp_ready_back", 64'(rnd_in_ready), 64'd1);
        chk("burst_g_rnd_1", 64'(g_rnd), 64'b10110);
        rnd_in_valid = 0;
        issue_op(10'h3A5, 10'h15A);
        chk("burst_g_rnd_2", 64'(g_rnd), 64'b10011);
        tick();
        chk("burst_res_1", 64'(res_valid), 64'd1);
        tick();
        chk("burst_res_2", 64'(res_valid), 64'd1);
        tick();
        chk("burst_res_end", 64'(res_valid), 64'd0);

        // Reset mid-flight with 3 partial words
        for (int i = 0; i < 8; i++) feed_word(RW'(i % 2));
        issue_op(10'h155, 10'h2AA);
        tick();
        rst = 1;
        tick();
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_op_ready", 64'(op_ready), 64'd0);
        rst = 0;
        for (int i = 0; i < 2; i++) feed_word(1'b1);
        chk("midrst_partial_dropped", 64'(op_ready), 64'd0);
        for (int i = 0; i < 3; i++) feed_word(1'b0);
        chk("midrst_refill", 64'(op_ready), 64'd1);
        issue_op(10'h3FF, 10'h001);
        repeat (5) tick();

        // Random traffic with random RNG gaps
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    issue_op(ND'($urandom), ND'($urandom));
                end
                ops_done = 1;
            end
            begin
                while (!ops_done) begin
                    rnd_in = RW'($urandom);
                    rnd_in_valid = ($urandom_range(0, 3) != 0);
                    tick();
                end
                rnd_in_valid = 0;
            end
        join

        repeat (6) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
